move_selector: RTL

Downstream consumer of the 722-bit board image and the analyze/reset strobes produced by the board storage stage. On each analyze strobe it snapshots the board and scans all 361 cells of the 19x19 grid, one cell per clock. Each empty cell is scored from its 8-neighbourhood, and the block reports the highest-scoring empty cell as the candidate move for the software partition. It is the first hardware evaluation stage of the Connect6 stream path.

---
 rtl/move_selector_if.sv | 23 ++
 rtl/move_selector.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/move_selector_if.sv
// Board-in / move-out bundle between the board storage stage and move_selector.
interface move_selector_if;
  logic [721:0] board;
  logic         analyze_normal;
  logic         reset_normal;
  logic         upgrade;
  logic         busy;
  logic         move_valid;
  logic [4:0]   best_row;
  logic [4:0]   best_col;
  logic [4:0]   best_score;
  logic         no_move;

  modport master (
    output board, analyze_normal, reset_normal, upgrade,
    input  busy, move_valid, best_row, best_col, best_score, no_move
  );

  modport slave (
    input  board, analyze_normal, reset_normal, upgrade,
    output busy, move_valid, best_row, best_col, best_score, no_move
  );
endinterface

// File: rtl/move_selector.sv
// Scans a snapshot of the 19x19 board one cell per clock and reports the
// highest-scoring empty cell, scored from own/opponent stones in its 8-neighbourhood.
module move_selector (
  input  logic           clk,
  input  logic           rst,
  move_selector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t       state, state_next;
  logic [721:0] snap;
  logic         upg;
  logic [4:0]   row, col;
  logic         found;
  logic [4:0]   best_row, best_col, best_score;
  logic         no_move;

  logic         load, clear, step, last, take;
  logic [3:0]   own_n, opp_n;
  logic [4:0]   score;
  logic [1:0]   center, nb;

  // Off-board coordinates read as empty.
  function automatic logic [1:0] cell_at(input logic [721:0] b, input int r, input int c);
    logic [721:0] sh;
    int unsigned  idx;
    if (r < 0 || r > 18 || c < 0 || c > 18) return 2'b00;
    idx = unsigned'(r * 19 + c);
    sh  = b >> (2 * (360 - idx));
    return sh[1:0];
  endfunction

  always_comb begin
    own_n  = '0;
    opp_n  = '0;
    nb     = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i != 4) begin
        nb = cell_at(snap, int'(row) + int'(i / 3) - 1, int'(col) + int'(i % 3) - 1);
        if (nb == 2'b01) own_n = own_n + 4'd1;
        if (nb == 2'b10) opp_n = opp_n + 4'd1;
      end
    end
    center = cell_at(snap, int'(row), int'(col));
    score  = upg ? ({1'b0, own_n} + {opp_n, 1'b0})
                 : ({own_n, 1'b0} + {1'b0, opp_n});
    take   = (center == 2'b00) && (!found || score > best_score);
    last   = (row == 5'd18) && (col == 5'd18);
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clear      = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.reset_normal) begin
          clear = 1'b1;
        end else if (bus.analyze_normal) begin
          load       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (bus.reset_normal) begin
          clear      = 1'b1;
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap       <= '0;
      upg        <= 1'b0;
      row        <= '0;
      col        <= '0;
      found      <= 1'b0;
      best_row   <= '0;
      best_col   <= '0;
      best_score <= '0;
      no_move    <= 1'b0;
    end else begin
      state <= state_next;
      if (clear) begin
        found      <= 1'b0;
        best_row   <= '0;
        best_col   <= '0;
        best_score <= '0;
        no_move    <= 1'b0;
      end
      if (load) begin
        snap  <= bus.board;
        upg   <= bus.upgrade;
        row   <= '0;
        col   <= '0;
        found <= 1'b0;
      end
      if (step) begin
        if (take) begin
          best_row   <= row;
          best_col   <= col;
          best_score <= score;
          found      <= 1'b1;
        end
        if (last) begin
          row <= '0;
          col <= '0;
        end else if (col == 5'd18) begin
          col <= '0;
          row <= row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
        // no_move settles on entry to DONE; stale results from a previous
        // board are zeroed when this scan finds nothing.
        if (last) begin
          no_move <= ~(found | take);
          if (!found && !take) begin
            best_row   <= '0;
            best_col   <= '0;
            best_score <= '0;
          end
        end
      end
    end
  end

  assign bus.busy       = (state == SCAN);
  assign bus.move_valid = (state == DONE);
  assign bus.best_row   = best_row;
  assign bus.best_col   = best_col;
  assign bus.best_score = best_score;
  assign bus.no_move    = no_move;
endmodule
